riscv_encoder: RTL and testbench
================================

# riscv_encoder

Streaming RV32I instruction encoder: accepts one symbolic instruction request per handshake (mnemonic, register indices, signed immediate) and emits packed 32-bit `riscvinst` words on a valid/ready output. It is the assembly-side counterpart of `riscvutil::disassemble` and feeds instruction-memory preload and self-checking test generators. It expands the `LI` pseudo-instruction into one or two words and range-checks every immediate.

## Interface
- No parameters.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready` at a rising edge.
- `in_op` input `ENC_OP_T` (6): mnemonic.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices (`REG_NAME_T` encoding).
- `in_imm` input 32: signed immediate or offset; for LUI/AUIPC, the unsigned 20-bit upper value.
- `out_valid` output 1: `out_instr` valid.
- `out_ready` input 1: consumer accepts the word on `out_valid && out_ready`.
- `out_instr` output 32: encoded word.
- `out_err` output 1: immediate out of range; `out_instr` is NOP `32'h0000_0013`.
- `out_last` output 1: last word of the current request.

## Operation
- Supported ops: ADD SUB XOR OR AND SLL SRL SRA SLT SLTU; ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU; LB LH LW LBU LHU; SB SH SW; BEQ BNE BLT BGE BLTU BGEU; JAL JALR LUI AUIPC; pseudo LI.
- Field packing follows the RV32I formats. For S-type, rs1 is the base register and rs2 is the data register. SUB/SRA/SRAI set funct7 = `7'h20`. Unused fields are 0.
- Immediate legality:
  - I/S/JALR/load: −2048..2047.
  - Shifts: 0..31.
  - B: even, −4096..4094.
  - JAL: even, −1048576..1048574.
  - LUI/AUIPC: 0..0xFFFFF.
  - An illegal immediate yields NOP with `out_err=1` and `out_last=1`.
- LI expansion:
  - If `in_imm` is in −2048..2047: one word, `ADDI rd, zero, imm`.
  - Otherwise: `LUI rd, (imm + 0x800)[31:12]`, then `ADDI rd, rd, sext(imm[11:0])`.
  - If `imm[11:0]==0`: only the LUI is emitted, with `out_last=1`.
  - LI never errors.
- The encoder has three states:
  - EMPTY: no word held.
  - HOLD: one word held, nothing pending.
  - HOLD2: the LUI word is held and the ADDI is queued in an internal register.
- State transitions:
  - EMPTY → HOLD or HOLD2 on accept.
  - HOLD → EMPTY on drain with no new accept.
  - HOLD → HOLD or HOLD2 on simultaneous drain and accept.
  - HOLD2 → HOLD on drain; the ADDI word loads into the output register with `out_last=1`.
- `in_ready = (state==EMPTY) || (state==HOLD && out_ready)`. It is combinational and is always low in HOLD2.
- `in_op` values outside the supported set produce NOP with `out_err=1`.

## Timing
- Reset values: `out_valid=0`, `out_instr=0`, `out_err=0`, `out_last=0`, state EMPTY, pending register 0. `in_ready=1` while in reset.
- Latency: a request accepted at edge N gives `out_valid=1` after edge N (visible in cycle N+1). The second LI word appears in the cycle after the first is taken.
- Sustained throughput is 1 word/cycle with `out_ready` tied high. Two-word LI stalls input for exactly one extra cycle.
- While `out_valid && !out_ready`, `out_instr`, `out_err` and `out_last` are stable.
- `rst_n` low mid-operation, including HOLD2, clears the output immediately (asynchronously) and drops the pending word. No partial sequence resumes after reset.

## Structure
- Add to `riscvutil`:
  - `ENC_OP_T` enum.
  - `NOP_INSTR` constant.
  - immediate-range constants.
  - automatic function `encode(ENC_OP_T, rd, rs1, rs2, imm) → {riscvinst, err}`, combinational, reusing `OPCODE_T` and the funct3 enums and packing through the `riscvinst` union.
- The module holds only the FSM, the output register and the pending-word register.
- No sub-module is needed; `encode` is also callable from benches as the reference model.

## Test plan
- ADD a0,a1,a2 → `0x00C58533`, `out_err=0`, `out_last=1`, one cycle after accept.
- SW a0, 8(sp) → `0x00A12423`. ADDI with imm 2048 → `0x00000013`, `out_err=1`.
- LI a0, `0x12345FFF` → `0x12346537` then `0xFFF50513`; `out_last` is 0 then 1; `in_ready` is low while HOLD2.
- LI a0, `0x00001000` → single `0x00001537`, `out_last=1`. BEQ with imm 3 → NOP, `out_err=1`.
- Backpressure: `out_ready` low for 3 cycles during LI → first word held stable, `in_ready=0`, no word lost or duplicated. Back-to-back ADDs with `out_ready=1` → one word per cycle.
- Assert `rst_n` low while in HOLD2 → `out_valid` drops without waiting for a clock edge; after release, the next request's word is emitted and the ADDI never appears.

Source files
------------

// File: rtl/riscv_encoder_pkg.sv
// riscvutil: shared RV32I definitions for the encoder and its benches.
// Provides the opcode/funct3 enums, the riscvinst packing union, the
// ENC_OP_T mnemonic set, immediate-range constants and the combinational
// encode() reference function used both by RTL and by test generators.
package riscvutil;

    typedef enum logic [4:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1, A0, A1, A2, A3, A4, A5,
        A6, A7, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, T3, T4, T5, T6
    } REG_NAME_T;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F
    } OPCODE_T;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
        F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7
    } ALU_F3_T;

    typedef enum logic [2:0] {
        F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4,
        F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7
    } BR_F3_T;

    typedef enum logic [2:0] {
        F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5
    } LS_F3_T;

    typedef enum logic [5:0] {
        ENC_ADD, ENC_SUB, ENC_XOR, ENC_OR, ENC_AND, ENC_SLL, ENC_SRL, ENC_SRA,
        ENC_SLT, ENC_SLTU,
        ENC_ADDI, ENC_XORI, ENC_ORI, ENC_ANDI, ENC_SLLI, ENC_SRLI, ENC_SRAI,
        ENC_SLTI, ENC_SLTIU,
        ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU,
        ENC_SB, ENC_SH, ENC_SW,
        ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU,
        ENC_JAL, ENC_JALR, ENC_LUI, ENC_AUIPC,
        ENC_LI
    } ENC_OP_T;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        OPCODE_T    opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        OPCODE_T     opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm_11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4_0;
        OPCODE_T    opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4_1;
        logic       imm_11;
        OPCODE_T    opcode;
    } b_type_t;

    typedef struct packed {
        logic [19:0] imm_31_12;
        logic [4:0]  rd;
        OPCODE_T     opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm_20;
        logic [9:0] imm_10_1;
        logic       imm_11;
        logic [7:0] imm_19_12;
        logic [4:0] rd;
        OPCODE_T    opcode;
    } j_type_t;

    typedef union packed {
        r_type_t     r;
        i_type_t     i;
        s_type_t     s;
        b_type_t     b;
        u_type_t     u;
        j_type_t     j;
        logic [31:0] bits;
    } riscvinst;

    typedef struct packed {
        riscvinst inst;
        logic     err;
    } enc_result_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;
    localparam int IMM_U_MAX = 32'h000F_FFFF;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [2:0] alu_f3(input ENC_OP_T op);
        case (op)
            ENC_SLL,  ENC_SLLI:                     return F3_SLL;
            ENC_SLT,  ENC_SLTI:                     return F3_SLT;
            ENC_SLTU, ENC_SLTIU:                    return F3_SLTU;
            ENC_XOR,  ENC_XORI:                     return F3_XOR;
            ENC_SRL,  ENC_SRA, ENC_SRLI, ENC_SRAI:  return F3_SR;
            ENC_OR,   ENC_ORI:                      return F3_OR;
            ENC_AND,  ENC_ANDI:                     return F3_AND;
            default:                                return F3_ADD;
        endcase
    endfunction

    function automatic logic [2:0] ls_f3(input ENC_OP_T op);
        case (op)
            ENC_LH, ENC_SH: return F3_H;
            ENC_LW, ENC_SW: return F3_W;
            ENC_LBU:        return F3_BU;
            ENC_LHU:        return F3_HU;
            default:        return F3_B;
        endcase
    endfunction

    function automatic logic [2:0] br_f3(input ENC_OP_T op);
        case (op)
            ENC_BNE:  return F3_BNE;
            ENC_BLT:  return F3_BLT;
            ENC_BGE:  return F3_BGE;
            ENC_BLTU: return F3_BLTU;
            ENC_BGEU: return F3_BGEU;
            default:  return F3_BEQ;
        endcase
    endfunction

    // LI needs a trailing ADDI only when LUI alone cannot reach the value.
    function automatic logic li_needs_tail(input logic [31:0] imm);
        return !in_range(signed'(imm), IMM_I_MIN, IMM_I_MAX) && (imm[11:0] != 12'h000);
    endfunction

    function automatic riscvinst li_tail(input logic [4:0] rd, input logic [11:0] lo);
        riscvinst w;
        w.bits     = '0;
        w.i.opcode = OPC_OP_IMM;
        w.i.rd     = rd;
        w.i.rs1    = rd;
        w.i.funct3 = F3_ADD;
        w.i.imm    = lo;
        return w;
    endfunction

    // For LI this returns the first word only (ADDI or LUI); the tail ADDI
    // comes from li_tail().
    function automatic enc_result_t encode(input ENC_OP_T op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        riscvinst    w;
        logic        err;
        int          simm;
        logic [31:0] li_hi;
        enc_result_t res;
        w.bits = '0;
        err    = 1'b0;
        simm   = signed'(imm);
        li_hi  = imm + 32'h0000_0800;
        case (op)
            ENC_ADD, ENC_SUB, ENC_XOR, ENC_OR, ENC_AND, ENC_SLL, ENC_SRL,
            ENC_SRA, ENC_SLT, ENC_SLTU: begin
                w.r.opcode = OPC_OP;
                w.r.rd     = rd;
                w.r.rs1    = rs1;
                w.r.rs2    = rs2;
                w.r.funct3 = alu_f3(op);
                w.r.funct7 = (op == ENC_SUB || op == ENC_SRA) ? 7'h20 : 7'h00;
            end
            ENC_ADDI, ENC_XORI, ENC_ORI, ENC_ANDI, ENC_SLTI, ENC_SLTIU: begin
                err        = !in_range(simm, IMM_I_MIN, IMM_I_MAX);
                w.i.opcode = OPC_OP_IMM;
                w.i.rd     = rd;
                w.i.rs1    = rs1;
                w.i.funct3 = alu_f3(op);
                w.i.imm    = imm[11:0];
            end
            // Shift-immediates pack shamt into the rs2 slot of an R layout.
            ENC_SLLI, ENC_SRLI, ENC_SRAI: begin
                err        = !in_range(simm, 0, SHAMT_MAX);
                w.r.opcode = OPC_OP_IMM;
                w.r.rd     = rd;
                w.r.rs1    = rs1;
                w.r.rs2    = imm[4:0];
                w.r.funct3 = alu_f3(op);
                w.r.funct7 = (op == ENC_SRAI) ? 7'h20 : 7'h00;
            end
            ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU: begin
                err        = !in_range(simm, IMM_I_MIN, IMM_I_MAX);
                w.i.opcode = OPC_LOAD;
                w.i.rd     = rd;
                w.i.rs1    = rs1;
                w.i.funct3 = ls_f3(op);
                w.i.imm    = imm[11:0];
            end
            ENC_SB, ENC_SH, ENC_SW: begin
                err          = !in_range(simm, IMM_I_MIN, IMM_I_MAX);
                w.s.opcode   = OPC_STORE;
                w.s.rs1      = rs1;
                w.s.rs2      = rs2;
                w.s.funct3   = ls_f3(op);
                w.s.imm_11_5 = imm[11:5];
                w.s.imm_4_0  = imm[4:0];
            end
            ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU: begin
                err          = !in_range(simm, IMM_B_MIN, IMM_B_MAX) || imm[0];
                w.b.opcode   = OPC_BRANCH;
                w.b.rs1      = rs1;
                w.b.rs2      = rs2;
                w.b.funct3   = br_f3(op);
                w.b.imm_12   = imm[12];
                w.b.imm_11   = imm[11];
                w.b.imm_10_5 = imm[10:5];
                w.b.imm_4_1  = imm[4:1];
            end
            ENC_JAL: begin
                err           = !in_range(simm, IMM_J_MIN, IMM_J_MAX) || imm[0];
                w.j.opcode    = OPC_JAL;
                w.j.rd        = rd;
                w.j.imm_20    = imm[20];
                w.j.imm_19_12 = imm[19:12];
                w.j.imm_11    = imm[11];
                w.j.imm_10_1  = imm[10:1];
            end
            ENC_JALR: begin
                err        = !in_range(simm, IMM_I_MIN, IMM_I_MAX);
                w.i.opcode = OPC_JALR;
                w.i.rd     = rd;
                w.i.rs1    = rs1;
                w.i.funct3 = 3'd0;
                w.i.imm    = imm[11:0];
            end
            ENC_LUI, ENC_AUIPC: begin
                err           = !in_range(simm, 0, IMM_U_MAX);
                w.u.opcode    = (op == ENC_LUI) ? OPC_LUI : OPC_AUIPC;
                w.u.rd        = rd;
                w.u.imm_31_12 = imm[19:0];
            end
            ENC_LI: begin
                if (in_range(simm, IMM_I_MIN, IMM_I_MAX)) begin
                    w.i.opcode = OPC_OP_IMM;
                    w.i.rd     = rd;
                    w.i.funct3 = F3_ADD;
                    w.i.imm    = imm[11:0];
                end else begin
                    // +0x800 pre-compensates the sign extension of the tail ADDI.
                    w.u.opcode    = OPC_LUI;
                    w.u.rd        = rd;
                    w.u.imm_31_12 = li_hi[31:12];
                end
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            w.bits = NOP_INSTR;
        end
        res.inst = w;
        res.err  = err;
        return res;
    endfunction

endpackage

// File: rtl/riscv_encoder.sv
// riscv_encoder: streaming RV32I encoder. One symbolic request per in_*
// handshake becomes one packed word (two for a far LI) on the out_* side.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            request handshake
//   in_op, in_rd/rs1/rs2, in_imm mnemonic (ENC_OP_T), registers, immediate
//   out_valid/out_ready          word handshake
//   out_instr, out_err, out_last encoded word, range error, last-of-request
module riscv_encoder
    import riscvutil::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_HOLD2} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pend_q,  pend_d;
    logic        err_q,   err_d;
    logic        last_q,  last_d;

    enc_result_t first_w;
    riscvinst    tail_w;
    logic        two_words;
    logic        accept;

    always_comb begin
        first_w   = encode(ENC_OP_T'(in_op), in_rd, in_rs1, in_rs2, in_imm);
        tail_w    = li_tail(in_rd, in_imm[11:0]);
        two_words = (ENC_OP_T'(in_op) == ENC_LI) && li_needs_tail(in_imm);
    end

    assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        err_d   = err_q;
        last_d  = last_q;
        if (accept) begin
            instr_d = first_w.inst.bits;
            err_d   = first_w.err;
            last_d  = !two_words;
            pend_d  = two_words ? tail_w.bits : '0;
            state_d = two_words ? ST_HOLD2 : ST_HOLD;
        end else if (state_q == ST_HOLD && out_ready) begin
            state_d = ST_EMPTY;
        end else if (state_q == ST_HOLD2 && out_ready) begin
            instr_d = pend_q;
            err_d   = 1'b0;
            last_d  = 1'b1;
            pend_d  = '0;
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_riscv_encoder.sv
// Directed-vector bench for riscv_encoder with hand-computed words.
module tb_riscv_encoder;
    import riscvutil::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        err;
        string       name;
    } vec_t;

    riscv_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Returns #1 after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input string nm);
        bit ok = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL %s accept: in_ready never rose within 20 cycles", nm);
        end
    endtask

    // Returns at a falling edge with out_valid high, or flags a timeout.
    task automatic wait_valid(input string nm);
        bit seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s wait: out_valid never rose within 20 cycles", nm);
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({out_valid, out_instr, out_err, out_last, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b instr=%h err=%b last=%b in_ready=%b, want 0 00000000 0 0 1",
                     out_valid, out_instr, out_err, out_last, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        out_ready = 1'b1;
        send(ENC_ADD, 5'd10, 5'd11, 5'd12, 32'd0, "add");
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency: got out_valid=%b one cycle after accept, want 1", out_valid);
        end
        wait_valid("add");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h00C58533, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL add: got %h err=%b last=%b, want 00c58533 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
        send(ENC_SUB, 5'd10, 5'd11, 5'd12, 32'd0, "sub");
        wait_valid("sub");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h40C58533, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sub: got %h err=%b last=%b, want 40c58533 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_imm_ranges();
        vec_t v[$];
        v.push_back('{ENC_ADDI,  5'd10, 5'd11, 5'd0,  32'hFFFF_FFFF, 32'hFFF58513, 1'b0, "addi_m1"});
        v.push_back('{ENC_ADDI,  5'd10, 5'd11, 5'd0,  32'd2047,      32'h7FF58513, 1'b0, "addi_2047"});
        v.push_back('{ENC_ADDI,  5'd10, 5'd11, 5'd0,  32'd2048,      32'h00000013, 1'b1, "addi_2048"});
        v.push_back('{ENC_ADDI,  5'd10, 5'd11, 5'd0,  32'hFFFF_F800, 32'h80058513, 1'b0, "addi_m2048"});
        v.push_back('{ENC_ADDI,  5'd10, 5'd11, 5'd0,  32'hFFFF_F7FF, 32'h00000013, 1'b1, "addi_m2049"});
        v.push_back('{ENC_SRAI,  5'd10, 5'd11, 5'd0,  32'd3,         32'h4035D513, 1'b0, "srai_3"});
        v.push_back('{ENC_SLLI,  5'd10, 5'd11, 5'd0,  32'd31,        32'h01F59513, 1'b0, "slli_31"});
        v.push_back('{ENC_SLLI,  5'd10, 5'd11, 5'd0,  32'd32,        32'h00000013, 1'b1, "slli_32"});
        v.push_back('{ENC_LW,    5'd10, 5'd2,  5'd0,  32'hFFFF_FFFC, 32'hFFC12503, 1'b0, "lw_m4"});
        v.push_back('{ENC_LUI,   5'd10, 5'd0,  5'd0,  32'h000F_FFFF, 32'hFFFFF537, 1'b0, "lui_max"});
        v.push_back('{ENC_LUI,   5'd10, 5'd0,  5'd0,  32'h0010_0000, 32'h00000013, 1'b1, "lui_over"});
        v.push_back('{ENC_AUIPC, 5'd10, 5'd0,  5'd0,  32'd1,         32'h00001517, 1'b0, "auipc_1"});
        v.push_back('{ENC_JALR,  5'd1,  5'd10, 5'd0,  32'd4,         32'h004500E7, 1'b0, "jalr_4"});
        out_ready = 1'b1;
        foreach (v[k]) begin
            send(v[k].op, v[k].rd, v[k].rs1, v[k].rs2, v[k].imm, v[k].name);
            wait_valid(v[k].name);
            n_vec++;
            if ({out_instr, out_err, out_last} !== {v[k].exp, v[k].err, 1'b1}) begin
                n_err++;
                $display("FAIL %s: got %h err=%b last=%b, want %h %b 1",
                         v[k].name, out_instr, out_err, out_last, v[k].exp, v[k].err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_branch_jump();
        vec_t v[$];
        v.push_back('{ENC_SW,  5'd0, 5'd2,  5'd10, 32'd8,         32'h00A12423, 1'b0, "sw_8_sp"});
        v.push_back('{ENC_BEQ, 5'd0, 5'd10, 5'd11, 32'd8,         32'h00B50463, 1'b0, "beq_8"});
        v.push_back('{ENC_BEQ, 5'd0, 5'd10, 5'd11, 32'hFFFF_F000, 32'h80B50063, 1'b0, "beq_m4096"});
        v.push_back('{ENC_BEQ, 5'd0, 5'd10, 5'd11, 32'd3,         32'h00000013, 1'b1, "beq_odd"});
        v.push_back('{ENC_BEQ, 5'd0, 5'd10, 5'd11, 32'd4096,      32'h00000013, 1'b1, "beq_4096"});
        v.push_back('{ENC_JAL, 5'd1, 5'd0,  5'd0,  32'd2048,      32'h001000EF, 1'b0, "jal_2048"});
        v.push_back('{ENC_JAL, 5'd1, 5'd0,  5'd0,  32'd1,         32'h00000013, 1'b1, "jal_odd"});
        v.push_back('{6'd63,   5'd1, 5'd2,  5'd3,  32'd0,         32'h00000013, 1'b1, "bad_op"});
        out_ready = 1'b1;
        foreach (v[k]) begin
            send(v[k].op, v[k].rd, v[k].rs1, v[k].rs2, v[k].imm, v[k].name);
            wait_valid(v[k].name);
            n_vec++;
            if ({out_instr, out_err, out_last} !== {v[k].exp, v[k].err, 1'b1}) begin
                n_err++;
                $display("FAIL %s: got %h err=%b last=%b, want %h %b 1",
                         v[k].name, out_instr, out_err, out_last, v[k].exp, v[k].err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_li();
        out_ready = 1'b1;
        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'h12345FFF, "li_far");
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL li_hold2_ready: got in_ready=%b, want 0", in_ready);
        end
        wait_valid("li_far_1");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h12346537, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL li_far_1: got %h err=%b last=%b, want 12346537 0 0", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
        wait_valid("li_far_2");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'hFFF50513, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL li_far_2: got %h err=%b last=%b, want fff50513 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;

        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'h00001000, "li_lui_only");
        wait_valid("li_lui_only");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h00001537, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL li_lui_only: got %h err=%b last=%b, want 00001537 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL li_lui_only_tail: got out_valid=%b after drain, want 0", out_valid);
        end

        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'd5, "li_small");
        wait_valid("li_small");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h00500513, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL li_small: got %h err=%b last=%b, want 00500513 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;

        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'hFFFF_F800, "li_m2048");
        wait_valid("li_m2048");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h80000513, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL li_m2048: got %h err=%b last=%b, want 80000513 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;

        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'd2048, "li_2048");
        wait_valid("li_2048_1");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h00001537, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL li_2048_1: got %h err=%b last=%b, want 00001537 0 0", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
        wait_valid("li_2048_2");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h80050513, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL li_2048_2: got %h err=%b last=%b, want 80050513 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'h12345FFF, "bp_li");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, out_instr, out_last, in_ready} !== {1'b1, 32'h12346537, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got valid=%b instr=%h last=%b in_ready=%b, want 1 12346537 0 0",
                         c, out_valid, out_instr, out_last, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_instr, out_last} !== {1'b1, 32'hFFF50513, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second: got valid=%b instr=%h last=%b, want 1 fff50513 1", out_valid, out_instr, out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_dup: got out_valid=%b after both words, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00C582B3; exp_w[1] = 32'h00C58333;
        exp_w[2] = 32'h00C583B3; exp_w[3] = 32'h00C58433;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = ENC_ADD; in_rd = 5'(i + 5);
            in_rs1 = 5'd11; in_rs2 = 5'd12; in_imm = '0;
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready %0d: got in_ready=%b, want 1", i, in_ready);
            end
            if (i > 0) begin
                n_vec++;
                if ({out_valid, out_instr} !== {1'b1, exp_w[i-1]}) begin
                    n_err++;
                    $display("FAIL b2b_word %0d: got valid=%b instr=%h, want 1 %h", i - 1, out_valid, out_instr, exp_w[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_instr} !== {1'b1, exp_w[3]}) begin
            n_err++;
            $display("FAIL b2b_word 3: got valid=%b instr=%h, want 1 %h", out_valid, out_instr, exp_w[3]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_hold2();
        out_ready = 1'b0;
        send(ENC_LI, 5'd10, 5'd0, 5'd0, 32'h12345FFF, "rst_li");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, out_instr, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_async: got valid=%b instr=%h in_ready=%b, want 0 00000000 1", out_valid, out_instr, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(ENC_ADD, 5'd10, 5'd11, 5'd12, 32'd0, "rst_add");
        wait_valid("rst_add");
        n_vec++;
        if ({out_instr, out_err, out_last} !== {32'h00C58533, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_add: got %h err=%b last=%b, want 00c58533 0 1", out_instr, out_err, out_last);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_tail cycle %0d: got out_valid=%b instr=%h, want 0", c, out_valid, out_instr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_imm = '0; out_ready = 1'b1;
        test_reset();
        test_r_type();
        test_imm_ranges();
        test_store_branch_jump();
        test_li();
        test_backpressure();
        test_back_to_back();
        test_reset_in_hold2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
